nw_traceback: RTL and testbench
===============================

// Module: nw_traceback
// PURPOSE
//  Reader side of the NW score matrix: after the grid/sequencer has filled a (len1+1)x(len2+1)
//  score memory, walks back from cell (len1,len2) to (0,0). Emits one alignment op per step on a
//  valid/ready stream, end of alignment first, and reports the final score. Row i uses s1[i-1],
//  col j uses s2[j-1]; "up" = (i-1,j) = gap in s2, "left" = (i,j-1) = gap in s1.
// PARAMETERS
//  MAX_LENGTH  10  max characters per string
//  AWIDTH      4   row/col index width; must satisfy 2**AWIDTH > MAX_LENGTH
//  CWIDTH      2   bits per character
//  SWIDTH      16  bits per signed score
//  MATCH       1   diagonal weight, equal chars (signed)
//  MISMATCH    -1  diagonal weight, unequal chars (signed)
//  INDEL       -1  gap weight (signed)
// PORTS
//  clk          in   1                    clock, rising edge
//  rst          in   1                    asynchronous, active-high reset
//  start        in   1                    begin traceback; sampled only in IDLE
//  len1         in   AWIDTH               s1 length (rows)
//  len2         in   AWIDTH               s2 length (cols)
//  s1           in   MAX_LENGTH*CWIDTH    s1 chars, char n at [n*CWIDTH +: CWIDTH]; stable while busy
//  s2           in   MAX_LENGTH*CWIDTH    s2 chars, same packing
//  rd_en        out  1                    score memory read strobe
//  rd_row       out  AWIDTH               read row index
//  rd_col       out  AWIDTH               read col index
//  rd_score     in   SWIDTH               signed data; valid exactly 1 cycle after rd_en
//  op_valid     out  1                    op available
//  op_ready     in   1                    consumer accepts op when op_valid&&op_ready
//  op           out  2                    00 MATCH, 01 MISMATCH, 10 UP, 11 LEFT
//  op_last      out  1                    with op_valid: final op (step reaching (0,0))
//  final_score  out  SWIDTH               score of (len1,len2); valid from first op until next start
//  busy         out  1                    traceback in progress
//  done         out  1                    one-cycle pulse at end
//  err          out  1                    with done: run aborted; held until next start
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE; asserted mid-run aborts immediately, no done pulse.
//  FSM: IDLE -> RD_CUR -> (i>0&&j>0 ? RD_NBR : EMIT) -> EMIT -> ... -> FIN -> IDLE.
//  IDLE: start=1 latches len1/len2 into i/j; busy=1 next cycle; err clears.
//   If len1>MAX_LENGTH or len2>MAX_LENGTH: go FIN with err=1, no reads/ops.
//  RD_CUR: one read of (len1,len2); data registered as cur and final_score.
//  RD_NBR: reads diag (i-1,j-1), up (i-1,j), left (i,j-1) on 3 consecutive cycles, back-to-back.
//   Last data arrives 1 cycle later; decide that cycle. Signed compare at SWIDTH+1 bits; no wrap.
//   Priority: cur==diag+(s1[i-1]==s2[j-1]?MATCH:MISMATCH) -> MATCH/MISMATCH, i--, j--;
//   else cur==up+INDEL -> UP, i--; else cur==left+INDEL -> LEFT, j--;
//   else err=1, FIN, no op emitted.
//   Chosen neighbour value becomes new cur; no re-read of cur.
//  Boundary: i==0,j>0 -> LEFT, j--; j==0,i>0 -> UP, i--; no neighbour reads.
//  EMIT: op_valid=1; op/op_last held stable until handshake. No reads while stalled.
//   On handshake: (i,j)==(0,0) after step -> FIN, else next step (RD_NBR or boundary EMIT).
//   Boundary ops issue 1 per cycle under continuous op_ready.
//  len1=len2=0: single read of (0,0), no ops, FIN.
//  FIN: done=1 for one cycle, busy=0, back to IDLE. start during busy ignored.
//  Op count = len1+len2 minus number of diagonal steps.
// TESTING
//  1 MATCH=1,MISMATCH=-1,INDEL=-1; s1="AC"(0,1), s2="AC"(0,1), len 2/2, matrix
//    [0 -1 -2; -1 1 0; -2 0 2] -> ops MATCH, MATCH(op_last); final_score=2; done, err=0.
//  2 s1="A"(0), s2="AC"(0,1), len 1/2, matrix [0 -1 -2; -1 1 0]
//    -> LEFT, MATCH(last); final_score=0.
//  3 len1=3, len2=0, (3,0)=-3 -> rd_en exactly once, then UP,UP,UP(last)
//    on 3 consecutive cycles with op_ready=1.
//  4 Test 1 with op_ready low 5 cycles on first op -> op/op_valid stable,
//    rd_en low throughout, same sequence after release.
//  5 Test 1 with (2,2) forced to 7 -> no op, done=1 with err=1; len1=11 -> err, no rd_en.
//  6 rst asserted during RD_NBR of test 1 -> all outputs 0 same edge, no done;
//    a following start completes test 1 correctly.

Source files
------------

// File: rtl/nw_traceback_if.sv
// Score-memory read port and alignment-op stream of the NW traceback unit.
// master = traceback side, slave = score memory / op consumer side.
interface nw_traceback_if #(
   parameter int unsigned AWIDTH = 4,
   parameter int unsigned SWIDTH = 16
);
   logic              rd_en;
   logic [AWIDTH-1:0] rd_row;
   logic [AWIDTH-1:0] rd_col;
   logic [SWIDTH-1:0] rd_score;
   logic              op_valid;
   logic              op_ready;
   logic [1:0]        op;
   logic              op_last;

   modport master (
      output rd_en, rd_row, rd_col, op_valid, op, op_last,
      input  rd_score, op_ready
   );

   modport slave (
      input  rd_en, rd_row, rd_col, op_valid, op, op_last,
      output rd_score, op_ready
   );
endinterface

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks the filled score matrix from (len1,len2) back to (0,0),
// streaming one alignment op per step (end of alignment first) and reporting the final score.
module nw_traceback #(
   parameter int unsigned MAX_LENGTH = 10,
   parameter int unsigned AWIDTH     = 4,
   parameter int unsigned CWIDTH     = 2,
   parameter int unsigned SWIDTH     = 16,
   parameter int          MATCH      = 1,
   parameter int          MISMATCH   = -1,
   parameter int          INDEL      = -1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [AWIDTH-1:0]            len1,
   input  logic [AWIDTH-1:0]            len2,
   input  logic [MAX_LENGTH*CWIDTH-1:0] s1,
   input  logic [MAX_LENGTH*CWIDTH-1:0] s2,
   nw_traceback_if.master               bus,
   output logic [SWIDTH-1:0]            final_score,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam logic [1:0] OpMatch    = 2'b00;
   localparam logic [1:0] OpMismatch = 2'b01;
   localparam logic [1:0] OpUp       = 2'b10;
   localparam logic [1:0] OpLeft     = 2'b11;

   localparam logic [AWIDTH-1:0]        MaxLen = AWIDTH'(MAX_LENGTH);
   localparam logic signed [SWIDTH:0]   WMatch = (SWIDTH+1)'(MATCH);
   localparam logic signed [SWIDTH:0]   WMis   = (SWIDTH+1)'(MISMATCH);
   localparam logic signed [SWIDTH:0]   WIndel = (SWIDTH+1)'(INDEL);

   typedef enum logic [2:0] {
      StIdle, StRdCur, StCapCur, StRdNbr, StDecide, StEmit, StFin
   } state_e;

   state_e                    state_q, state_d;
   logic [AWIDTH-1:0]         i_q, i_d, j_q, j_d;
   logic [1:0]                cnt_q, cnt_d;
   logic signed [SWIDTH-1:0]  cur_q, cur_d, diag_q, diag_d, up_q, up_d;
   logic [SWIDTH-1:0]         final_q, final_d;
   logic [1:0]                op_q, op_d;
   logic                      last_q, last_d;
   logic                      err_q, err_d;

   logic [CWIDTH-1:0]         c1, c2;
   logic [1:0]                bnd_op;
   logic [AWIDTH-1:0]         bnd_i, bnd_j;
   logic                      bnd_last;
   logic signed [SWIDTH:0]    cur_x, diag_x, up_x, left_x, diag_w;
   logic                      hit_diag, hit_up, hit_left;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         cnt_q   <= '0;
         cur_q   <= '0;
         diag_q  <= '0;
         up_q    <= '0;
         final_q <= '0;
         op_q    <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         diag_q  <= diag_d;
         up_q    <= up_d;
         final_q <= final_d;
         op_q    <= op_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   // Characters s1[i-1] and s2[j-1] for the current cell.
   always_comb begin
      c1 = '0;
      c2 = '0;
      for (int n = 0; n < int'(MAX_LENGTH); n++) begin
         if (n + 1 == int'(i_q)) c1 = s1[n*CWIDTH +: CWIDTH];
         if (n + 1 == int'(j_q)) c2 = s2[n*CWIDTH +: CWIDTH];
      end
   end

   // Step along row 0 or column 0; only meaningful when exactly one index is zero.
   always_comb begin
      bnd_op   = (j_q == '0) ? OpUp : OpLeft;
      bnd_i    = (j_q == '0) ? i_q - 1'b1 : i_q;
      bnd_j    = (j_q == '0) ? j_q : j_q - 1'b1;
      bnd_last = (bnd_i == '0) && (bnd_j == '0);
   end

   // One extra bit so neighbour + weight can never wrap.
   always_comb begin
      cur_x    = (SWIDTH+1)'(cur_q);
      diag_x   = (SWIDTH+1)'(diag_q);
      up_x     = (SWIDTH+1)'(up_q);
      left_x   = (SWIDTH+1)'(signed'(bus.rd_score));
      diag_w   = (c1 == c2) ? WMatch : WMis;
      hit_diag = (cur_x == diag_x + diag_w);
      hit_up   = (cur_x == up_x + WIndel);
      hit_left = (cur_x == left_x + WIndel);
   end

   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      cnt_d      = cnt_q;
      cur_d      = cur_q;
      diag_d     = diag_q;
      up_d       = up_q;
      final_d    = final_q;
      op_d       = op_q;
      last_d     = last_q;
      err_d      = err_q;
      bus.rd_en  = 1'b0;
      bus.rd_row = '0;
      bus.rd_col = '0;
      bus.op_valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               i_d   = len1;
               j_d   = len2;
               err_d = 1'b0;
               if (len1 > MaxLen || len2 > MaxLen) begin
                  err_d   = 1'b1;
                  state_d = StFin;
               end else begin
                  state_d = StRdCur;
               end
            end
         end
         StRdCur: begin
            bus.rd_en  = 1'b1;
            bus.rd_row = i_q;
            bus.rd_col = j_q;
            state_d    = StCapCur;
         end
         StCapCur: begin
            cur_d   = signed'(bus.rd_score);
            final_d = bus.rd_score;
            if (i_q == '0 && j_q == '0) begin
               state_d = StFin;
            end else if (i_q != '0 && j_q != '0) begin
               cnt_d   = '0;
               state_d = StRdNbr;
            end else begin
               op_d    = bnd_op;
               last_d  = bnd_last;
               i_d     = bnd_i;
               j_d     = bnd_j;
               state_d = StEmit;
            end
         end
         StRdNbr: begin
            // Issue diag, up, left back-to-back; each datum lands on the following cycle.
            bus.rd_en = 1'b1;
            cnt_d     = cnt_q + 2'd1;
            case (cnt_q)
               2'd0: begin
                  bus.rd_row = i_q - 1'b1;
                  bus.rd_col = j_q - 1'b1;
               end
               2'd1: begin
                  bus.rd_row = i_q - 1'b1;
                  bus.rd_col = j_q;
                  diag_d     = signed'(bus.rd_score);
               end
               default: begin
                  bus.rd_row = i_q;
                  bus.rd_col = j_q - 1'b1;
                  up_d       = signed'(bus.rd_score);
                  state_d    = StDecide;
               end
            endcase
         end
         StDecide: begin
            if (hit_diag) begin
               op_d    = (c1 == c2) ? OpMatch : OpMismatch;
               last_d  = (i_q == AWIDTH'(1)) && (j_q == AWIDTH'(1));
               i_d     = i_q - 1'b1;
               j_d     = j_q - 1'b1;
               cur_d   = diag_q;
               state_d = StEmit;
            end else if (hit_up) begin
               op_d    = OpUp;
               last_d  = 1'b0;
               i_d     = i_q - 1'b1;
               cur_d   = up_q;
               state_d = StEmit;
            end else if (hit_left) begin
               op_d    = OpLeft;
               last_d  = 1'b0;
               j_d     = j_q - 1'b1;
               cur_d   = signed'(bus.rd_score);
               state_d = StEmit;
            end else begin
               err_d   = 1'b1;
               state_d = StFin;
            end
         end
         StEmit: begin
            bus.op_valid = 1'b1;
            if (bus.op_ready) begin
               if (i_q == '0 && j_q == '0) begin
                  state_d = StFin;
               end else if (i_q != '0 && j_q != '0) begin
                  cnt_d   = '0;
                  state_d = StRdNbr;
               end else begin
                  op_d   = bnd_op;
                  last_d = bnd_last;
                  i_d    = bnd_i;
                  j_d    = bnd_j;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.op      = op_q;
   assign bus.op_last = last_q;
   assign final_score = final_q;
   assign err         = err_q;
   assign done        = (state_q == StFin);
   assign busy        = (state_q != StIdle) && (state_q != StFin);

endmodule

// File: tb/tb_nw_traceback.sv
// Directed bench for nw_traceback: behavioural score memory, op-stream monitor and
// hand-computed expectations for small alignments, stalls, errors and mid-run reset.
module tb_nw_traceback;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  len1 = '0, len2 = '0;
   logic [19:0] s1 = '0, s2 = '0;
   logic [15:0] final_score;
   logic        busy, done, err;

   nw_traceback_if #(.AWIDTH(4), .SWIDTH(16)) bus ();

   nw_traceback dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .len1        (len1),
      .len2        (len2),
      .s1          (s1),
      .s2          (s2),
      .bus         (bus),
      .final_score (final_score),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   logic signed [15:0] mem [0:15][0:15];
   logic [2:0] ops[$];
   int         op_cyc[$];
   int         cyc = 0, rd_cnt = 0, done_cnt = 0;
   int         n_checks = 0, n_fail = 0;

   localparam logic [19:0] StrA  = 20'h0;
   localparam logic [19:0] StrAC = 20'h4;  // 'A'=0 at char 0, 'C'=1 at char 1

   always @(posedge clk or posedge rst) begin
      if (rst) bus.rd_score <= '0;
      else if (bus.rd_en) bus.rd_score <= mem[bus.rd_row][bus.rd_col];
   end

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         if (bus.rd_en) rd_cnt++;
         if (bus.op_valid && bus.op_ready) begin
            ops.push_back({bus.op_last, bus.op});
            op_cyc.push_back(cyc);
         end
         if (done) done_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Missing ops read as 0 so they never match {present, op}.
   task automatic check_op(input string tag, input int idx, input logic [2:0] exp);
      logic [3:0] obs;
      obs = (idx < ops.size()) ? {1'b1, ops[idx]} : 4'b0;
      check_eq(tag, 32'(obs), 32'({1'b1, exp}));
   endtask

   task automatic load_mat1();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) mem[r][c] = '0;
      mem[0][0] = 0;  mem[0][1] = -1; mem[0][2] = -2;
      mem[1][0] = -1; mem[1][1] = 1;  mem[1][2] = 0;
      mem[2][0] = -2; mem[2][1] = 0;  mem[2][2] = 2;
   endtask

   task automatic start_run(input logic [3:0] l1, input logic [3:0] l2,
                            input logic [19:0] a, input logic [19:0] b);
      @(negedge clk);
      len1 = l1; len2 = l2; s1 = a; s2 = b;
      ops.delete(); op_cyc.delete();
      rd_cnt = 0; done_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (done_cnt == 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      check_eq(tag, 32'(done_cnt), 32'd1);
   endtask

   task automatic run_test1(input string tag);
      start_run(4'd2, 4'd2, StrAC, StrAC);
      wait_done({tag, "_done"});
      check_eq({tag, "_nops"}, 32'(ops.size()), 32'd2);
      check_op({tag, "_op0"}, 0, 3'b000);
      check_op({tag, "_op1"}, 1, 3'b100);
      check_eq({tag, "_final"}, 32'(final_score), 32'd2);
      check_eq({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      int k;
      logic [1:0] op_hold;
      bus.op_ready = 1'b1;
      load_mat1();
      #22;
      check_eq("rst_rd_en", 32'(bus.rd_en), 32'd0);
      check_eq("rst_op_valid", 32'(bus.op_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: two matches.
      start_run(4'd2, 4'd2, StrAC, StrAC);
      check_eq("t1_busy", 32'(busy), 32'd1);
      wait_done("t1_done");
      check_eq("t1_nops", 32'(ops.size()), 32'd2);
      check_op("t1_op0", 0, 3'b000);
      check_op("t1_op1", 1, 3'b100);
      check_eq("t1_final", 32'(final_score), 32'd2);
      check_eq("t1_err", 32'(err), 32'd0);
      check_eq("t1_rd", 32'(rd_cnt), 32'd7);
      check_eq("t1_busy_end", 32'(busy), 32'd0);

      // Test 2: LEFT then MATCH.
      start_run(4'd1, 4'd2, StrA, StrAC);
      wait_done("t2_done");
      check_eq("t2_nops", 32'(ops.size()), 32'd2);
      check_op("t2_op0", 0, 3'b011);
      check_op("t2_op1", 1, 3'b100);
      check_eq("t2_final", 32'(final_score), 32'd0);

      // Test 3: column-0 boundary, ops back-to-back.
      mem[3][0] = -3;
      start_run(4'd3, 4'd0, StrA, StrA);
      wait_done("t3_done");
      check_eq("t3_rd", 32'(rd_cnt), 32'd1);
      check_eq("t3_nops", 32'(ops.size()), 32'd3);
      check_op("t3_op0", 0, 3'b010);
      check_op("t3_op1", 1, 3'b010);
      check_op("t3_op2", 2, 3'b110);
      check_eq("t3_consec", 32'((op_cyc.size() == 3) && (op_cyc[1] == op_cyc[0] + 1)
                                && (op_cyc[2] == op_cyc[0] + 2)), 32'd1);
      check_eq("t3_final", 32'(final_score), 32'(16'hfffd));

      // Test 4: back-pressure on the first op.
      bus.op_ready = 1'b0;
      start_run(4'd2, 4'd2, StrAC, StrAC);
      k = 0;
      while (!bus.op_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_eq("t4_valid_seen", 32'(bus.op_valid), 32'd1);
      op_hold = bus.op;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         check_eq("t4_stall_valid", 32'(bus.op_valid), 32'd1);
         check_eq("t4_stall_op", 32'({bus.op_last, bus.op}), 32'd0);
         check_eq("t4_stall_rd", 32'(bus.rd_en), 32'd0);
      end
      check_eq("t4_hold0", 32'(op_hold), 32'd0);
      bus.op_ready = 1'b1;
      wait_done("t4_done");
      check_eq("t4_nops", 32'(ops.size()), 32'd2);
      check_op("t4_op0", 0, 3'b000);
      check_op("t4_op1", 1, 3'b100);

      // Test 5: inconsistent matrix, then over-length input.
      mem[2][2] = 7;
      start_run(4'd2, 4'd2, StrAC, StrAC);
      wait_done("t5_done");
      check_eq("t5_err", 32'(err), 32'd1);
      check_eq("t5_nops", 32'(ops.size()), 32'd0);
      mem[2][2] = 2;
      start_run(4'd11, 4'd2, StrAC, StrAC);
      wait_done("t5b_done");
      check_eq("t5b_err", 32'(err), 32'd1);
      check_eq("t5b_rd", 32'(rd_cnt), 32'd0);
      check_eq("t5b_nops", 32'(ops.size()), 32'd0);

      // Test 6: reset during neighbour reads, then a clean rerun.
      start_run(4'd2, 4'd2, StrAC, StrAC);
      k = 0;
      while (rd_cnt < 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_eq("t6_in_nbr", 32'(bus.rd_en), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("t6_rd_en", 32'(bus.rd_en), 32'd0);
      check_eq("t6_busy", 32'(busy), 32'd0);
      check_eq("t6_op_valid", 32'(bus.op_valid), 32'd0);
      check_eq("t6_final", 32'(final_score), 32'd0);
      check_eq("t6_err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("t6_no_done", 32'(done_cnt), 32'd0);
      run_test1("t6_rerun");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
